// File: rtl/led_cmd_controller.sv
// UART-command LED controller: decodes ASCII global and opcode+index
// commands into per-LED on/off/toggle/blink state with ack/err pulses.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   received_data  : byte from the UART receiver
//   data_valid     : one-cycle strobe qualifying received_data
//   ledr_out       : registered LED drive (NUM_LEDS bits)
//   blink_mask     : per-LED blink-enable register
//   busy           : high while an opcode waits for its argument
//   cmd_ack        : one-cycle pulse, command executed
//   cmd_err        : one-cycle pulse, command rejected or timed out
module led_cmd_controller #(
    parameter int NUM_LEDS       = 10,
    parameter int BLINK_DIV      = 25000000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          received_data,
    input  logic                data_valid,
    output logic [NUM_LEDS-1:0] ledr_out,
    output logic [NUM_LEDS-1:0] blink_mask,
    output logic                busy,
    output logic                cmd_ack,
    output logic                cmd_err
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    N_LEDS4    = 4'(NUM_LEDS);

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_Z = 8'h5A;
    localparam logic [7:0] CH_S = 8'h53;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_T = 8'h54;
    localparam logic [7:0] CH_B = 8'h42;

    typedef enum logic {
        IDLE,
        WAIT_ARG
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          opcode;
    logic [7:0]          opcode_nxt;
    logic [TW-1:0]       to_cnt;
    logic [TW-1:0]       to_cnt_nxt;
    logic [NUM_LEDS-1:0] led_state;
    logic [NUM_LEDS-1:0] led_nxt;
    logic [NUM_LEDS-1:0] blink_en;
    logic [NUM_LEDS-1:0] blink_nxt;
    logic                ack_nxt;
    logic                err_nxt;
    logic [BW-1:0]       blink_cnt;
    logic                phase;
    logic [3:0]          arg_idx;
    logic                arg_ok;

    // ASCII '0'..'9' have the digit value in the low nibble.
    assign arg_idx = received_data[3:0];
    assign arg_ok  = (received_data >= 8'h30) &&
                     (received_data <= 8'h39) &&
                     (arg_idx < N_LEDS4);

    assign busy       = (state == WAIT_ARG);
    assign blink_mask = blink_en;

    // Free-running blink timebase, independent of command traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opcode    <= '0;
            to_cnt    <= '0;
            led_state <= '0;
            blink_en  <= '0;
            cmd_ack   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            opcode    <= opcode_nxt;
            to_cnt    <= to_cnt_nxt;
            led_state <= led_nxt;
            blink_en  <= blink_nxt;
            cmd_ack   <= ack_nxt;
            cmd_err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr_out <= '0;
        end else begin
            ledr_out <= (blink_en & {NUM_LEDS{phase}}) |
                        (~blink_en & led_state);
        end
    end

    always_comb begin
        state_nxt  = state;
        opcode_nxt = opcode;
        to_cnt_nxt = to_cnt;
        led_nxt    = led_state;
        blink_nxt  = blink_en;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (data_valid) begin
                    unique case (received_data)
                        CH_A: begin
                            led_nxt   = '1;
                            blink_nxt = '0;
                            ack_nxt   = 1'b1;
                        end
                        CH_Z: begin
                            led_nxt   = '0;
                            blink_nxt = '0;
                            ack_nxt   = 1'b1;
                        end
                        CH_S, CH_R, CH_T, CH_B: begin
                            opcode_nxt = received_data;
                            to_cnt_nxt = '0;
                            state_nxt  = WAIT_ARG;
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
            end

            WAIT_ARG: begin
                // An arriving byte always takes priority over timeout.
                if (data_valid) begin
                    state_nxt = IDLE;
                    if (arg_ok) begin
                        ack_nxt = 1'b1;
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (arg_idx == 4'(i)) begin
                                case (opcode)
                                    CH_S: begin
                                        led_nxt[i]   = 1'b1;
                                        blink_nxt[i] = 1'b0;
                                    end
                                    CH_R: begin
                                        led_nxt[i]   = 1'b0;
                                        blink_nxt[i] = 1'b0;
                                    end
                                    CH_T: begin
                                        led_nxt[i]   = ~led_state[i];
                                        blink_nxt[i] = 1'b0;
                                    end
                                    CH_B: blink_nxt[i] = 1'b1;
                                    default: ;
                                endcase
                            end
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (to_cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_cmd_controller.sv
// Testbench for led_cmd_controller: directed scenarios plus a random
// byte stream, checked against a command-level model of both instances.
module tb_led_cmd_controller;

    localparam int BD = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx = 8'h00;
    logic       dv = 1'b0;

    logic [9:0] led10, bm10;
    logic       busy10, ack10, err10;
    logic [3:0] led4, bm4;
    logic       busy4, ack4, err4;

    int total = 0;
    int bad = 0;
    int edges;

    int m_led[2];
    int m_blink[2];
    int m_pend[2];
    int nled[2] = '{10, 4};

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else edges <= edges + 1;
    end

    led_cmd_controller #(
        .NUM_LEDS(10), .BLINK_DIV(BD), .TIMEOUT_CYCLES(TO)
    ) dut10 (
        .clk(clk), .rst_n(rst_n),
        .received_data(rx), .data_valid(dv),
        .ledr_out(led10), .blink_mask(bm10), .busy(busy10),
        .cmd_ack(ack10), .cmd_err(err10)
    );

    led_cmd_controller #(
        .NUM_LEDS(4), .BLINK_DIV(BD), .TIMEOUT_CYCLES(TO)
    ) dut4 (
        .clk(clk), .rst_n(rst_n),
        .received_data(rx), .data_valid(dv),
        .ledr_out(led4), .blink_mask(bm4), .busy(busy4),
        .cmd_ack(ack4), .cmd_err(err4)
    );

    // Command-level model: what each byte means, not how it is built.
    function automatic void model_byte(input int d, input int b,
                                       output bit a, output bit e);
        int all;
        int idx;
        int bit_m;
        a = 0;
        e = 0;
        all = (1 << nled[d]) - 1;
        if (m_pend[d] == 0) begin
            if (b == "A") begin
                m_led[d] = all; m_blink[d] = 0; a = 1;
            end else if (b == "Z") begin
                m_led[d] = 0; m_blink[d] = 0; a = 1;
            end else if (b == "S" || b == "R" || b == "T" || b == "B") begin
                m_pend[d] = b;
            end else begin
                e = 1;
            end
        end else begin
            idx = b - "0";
            if (b >= "0" && b <= "9" && idx < nled[d]) begin
                bit_m = 1 << idx;
                case (m_pend[d])
                    "S": begin m_led[d] |= bit_m; m_blink[d] &= ~bit_m; end
                    "R": begin m_led[d] &= ~bit_m; m_blink[d] &= ~bit_m; end
                    "T": begin m_led[d] ^= bit_m; m_blink[d] &= ~bit_m; end
                    default: m_blink[d] |= bit_m;
                endcase
                a = 1;
            end else begin
                e = 1;
            end
            m_pend[d] = 0;
        end
    endfunction

    // Blink phase flips once every BD cycles counted from reset release.
    function automatic int exp_ledr(input int d);
        int ph;
        int r;
        ph = ((edges - 1) / BD) % 2;
        r = 0;
        for (int i = 0; i < nled[d]; i++) begin
            if ((m_blink[d] >> i) & 1) r |= ph << i;
            else r |= m_led[d] & (1 << i);
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_led[d] = 0; m_blink[d] = 0; m_pend[d] = 0;
        end
    endfunction

    task automatic step(input logic [7:0] b, input logic v);
        rx = b;
        dv = v;
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        total++;
        if ({led10, bm10, busy10, ack10, err10} !== 23'h0) begin
            bad++;
            $display("FAIL reset10 got=%h want=0",
                     {led10, bm10, busy10, ack10, err10});
        end
        total++;
        if ({led4, bm4, busy4, ack4, err4} !== 11'h0) begin
            bad++;
            $display("FAIL reset4 got=%h want=0",
                     {led4, bm4, busy4, ack4, err4});
        end
        release_reset();
    endtask

    task automatic test_set();
        bit a, e, a4, e4;
        step("S", 1'b1);
        model_byte(0, "S", a, e);
        model_byte(1, "S", a4, e4);
        total++;
        if ({busy10, ack10, err10} !== 3'b100) begin
            bad++;
            $display("FAIL set_op got=%b want=100", {busy10, ack10, err10});
        end
        step("3", 1'b1);
        model_byte(0, "3", a, e);
        model_byte(1, "3", a4, e4);
        total++;
        if ({busy10, ack10, err10, led10} !== {3'b010, 10'h000}) begin
            bad++;
            $display("FAIL set_arg got=%b/%h want=010/000",
                     {busy10, ack10, err10}, led10);
        end
        total++;
        if ({ack4, err4} !== {a4, e4}) begin
            bad++;
            $display("FAIL set_arg4 got=%b want=%b", {ack4, err4}, {a4, e4});
        end
        step(8'h00, 1'b0);
        total++;
        if ({ack10, led10} !== {1'b0, 10'h008}) begin
            bad++;
            $display("FAIL set_led got=%b/%h want=0/008", ack10, led10);
        end
    endtask

    task automatic test_sequence();
        string cmds[4] = '{"A", "R0", "T9", "T9"};
        int want[4] = '{'h3FF, 'h3FE, 'h1FE, 'h3FE};
        int acks = 0;
        int errs = 0;
        bit a, e, a4, e4;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < cmds[k].len(); c++) begin
                step(cmds[k][c], 1'b1);
                model_byte(0, cmds[k][c], a, e);
                model_byte(1, cmds[k][c], a4, e4);
                acks += int'(ack10);
                errs += int'(err10);
                total++;
                if ({ack4, err4} !== {a4, e4}) begin
                    bad++;
                    $display("FAIL seq4 byte=%s got=%b want=%b",
                             cmds[k][c], {ack4, err4}, {a4, e4});
                end
            end
            step(8'h00, 1'b0);
            acks += int'(ack10);
            errs += int'(err10);
            total++;
            if (led10 !== 10'(want[k])) begin
                bad++;
                $display("FAIL seq_led k=%0d got=%h want=%h",
                         k, led10, want[k]);
            end
        end
        total++;
        if (acks != 4 || errs != 0) begin
            bad++;
            $display("FAIL seq_pulses got=%0d/%0d want=4/0", acks, errs);
        end
    endtask

    task automatic test_blink();
        string cmds = "ZB5";
        bit a, e, a4, e4;
        for (int c = 0; c < cmds.len(); c++) begin
            step(cmds[c], 1'b1);
            model_byte(0, cmds[c], a, e);
            model_byte(1, cmds[c], a4, e4);
        end
        step(8'h00, 1'b0);
        total++;
        if (bm10 !== 10'h020) begin
            bad++;
            $display("FAIL blink_mask got=%h want=020", bm10);
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (led10 !== 10'(exp_ledr(0)) || led4 !== 4'(exp_ledr(1))) begin
                bad++;
                $display("FAIL blink_led k=%0d got=%h/%h want=%h/%h", k,
                         led10, led4, exp_ledr(0), exp_ledr(1));
            end
            step(8'h00, 1'b0);
        end
        step("S", 1'b1);
        model_byte(0, "S", a, e);
        model_byte(1, "S", a4, e4);
        step("5", 1'b1);
        model_byte(0, "5", a, e);
        model_byte(1, "5", a4, e4);
        for (int k = 0; k < 8; k++) begin
            step(8'h00, 1'b0);
            total++;
            if ({bm10, led10} !== {10'h000, 10'h020}) begin
                bad++;
                $display("FAIL blink_off k=%0d got=%h/%h want=000/020",
                         k, bm10, led10);
            end
        end
    endtask

    task automatic test_errors();
        string cmds[4] = '{"Q", "SX", "S7", "A"};
        bit a, e, a4, e4;
        logic [9:0] snap10;
        logic [3:0] snap4;
        for (int k = 0; k < 4; k++) begin
            snap10 = led10;
            snap4 = led4;
            for (int c = 0; c < cmds[k].len(); c++) begin
                step(cmds[k][c], 1'b1);
                model_byte(0, cmds[k][c], a, e);
                model_byte(1, cmds[k][c], a4, e4);
            end
            total++;
            if ({ack10, err10, ack4, err4} !== {a, e, a4, e4}) begin
                bad++;
                $display("FAIL err_pulse k=%0d got=%b want=%b", k,
                         {ack10, err10, ack4, err4}, {a, e, a4, e4});
            end
            step(8'h00, 1'b0);
            total++;
            if (led10 !== 10'(exp_ledr(0)) || led4 !== 4'(exp_ledr(1))) begin
                bad++;
                $display("FAIL err_led k=%0d got=%h/%h want=%h/%h", k,
                         led10, led4, exp_ledr(0), exp_ledr(1));
            end
            if (k < 2) begin
                total++;
                if (led10 !== snap10 || led4 !== snap4) begin
                    bad++;
                    $display("FAIL err_nochg k=%0d got=%h/%h want=%h/%h",
                             k, led10, led4, snap10, snap4);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit a, e, a4, e4;
        logic [9:0] snap10;
        int busy_cnt;
        for (int rep = 0; rep < 2; rep++) begin
            snap10 = led10;
            busy_cnt = 0;
            step("T", 1'b1);
            model_byte(0, "T", a, e);
            model_byte(1, "T", a4, e4);
            busy_cnt += int'(busy10);
            for (int k = 0; k < TO - 1; k++) begin
                step(8'h00, 1'b0);
                busy_cnt += int'(busy10 && !err10 && !ack10);
            end
            total++;
            if (busy_cnt != TO) begin
                bad++;
                $display("FAIL to_busy rep=%0d got=%0d want=%0d",
                         rep, busy_cnt, TO);
            end
            if (rep == 0) begin
                step(8'h00, 1'b0);
                m_pend[0] = 0;
                m_pend[1] = 0;
                total++;
                if ({busy10, ack10, err10, ack4, err4} !== 5'b00101) begin
                    bad++;
                    $display("FAIL to_err got=%b want=00101",
                             {busy10, ack10, err10, ack4, err4});
                end
                step(8'h00, 1'b0);
                total++;
                if (led10 !== snap10) begin
                    bad++;
                    $display("FAIL to_nochg got=%h want=%h", led10, snap10);
                end
            end else begin
                step("2", 1'b1);
                model_byte(0, "2", a, e);
                model_byte(1, "2", a4, e4);
                total++;
                if ({ack10, err10, ack4, err4} !== 4'b1010) begin
                    bad++;
                    $display("FAIL to_late got=%b want=1010",
                             {ack10, err10, ack4, err4});
                end
                step(8'h00, 1'b0);
                total++;
                if (led10 !== 10'(exp_ledr(0))) begin
                    bad++;
                    $display("FAIL to_late_led got=%h want=%h",
                             led10, exp_ledr(0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit a, e, a4, e4;
        step("A", 1'b1);
        step(8'h00, 1'b0);
        step("S", 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({led10, bm10, busy10, ack10, err10} !== 23'h0) begin
            bad++;
            $display("FAIL rst_mid got=%h want=0",
                     {led10, bm10, busy10, ack10, err10});
        end
        release_reset();
        step("3", 1'b1);
        model_byte(0, "3", a, e);
        model_byte(1, "3", a4, e4);
        total++;
        if ({ack10, err10, ack4, err4} !== 4'b0101) begin
            bad++;
            $display("FAIL rst_discard got=%b want=0101",
                     {ack10, err10, ack4, err4});
        end
    endtask

    task automatic test_random();
        string alpha = "ASRTBZQX0123456789";
        int b;
        int gap;
        bit a, e, a4, e4;
        for (int n = 0; n < 150; n++) begin
            b = alpha[$urandom_range(0, alpha.len() - 1)];
            step(8'(b), 1'b1);
            model_byte(0, b, a, e);
            model_byte(1, b, a4, e4);
            total++;
            if ({ack10, err10, ack4, err4} !== {a, e, a4, e4}) begin
                bad++;
                $display("FAIL rnd_pulse n=%0d byte=%h got=%b want=%b", n, b,
                         {ack10, err10, ack4, err4}, {a, e, a4, e4});
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(8'h00, 1'b0);
                total++;
                if ({ack10, err10, ack4, err4} !== 4'b0000 ||
                    led10 !== 10'(exp_ledr(0)) ||
                    led4 !== 4'(exp_ledr(1)) ||
                    bm10 !== 10'(m_blink[0]) ||
                    busy10 !== (m_pend[0] != 0)) begin
                    bad++;
                    $display("FAIL rnd_idle n=%0d got=%h/%h/%h want=%h/%h/%h",
                             n, led10, led4, bm10,
                             exp_ledr(0), exp_ledr(1), m_blink[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_sequence();
        test_blink();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
